id_hazard_scoreboard: RTL and testbench

Parametrised hazard, forwarding and register-file block for the decode stage. It holds the architectural register file with write-through bypass. It tracks every in-flight destination register in a shift-register scoreboard spanning EX through WB, and generates per-source forwarding selects and load-use stalls for any number of read ports. It sits between fetch/decode and the ID/EX pipeline register. It replaces the fixed two-port, fixed-depth forwarding logic with a depth- and port-count-generic scoreboard that also supports flush.

---
 rtl/id_hazard_scoreboard_if.sv | 39 +++
 rtl/id_hazard_scoreboard.sv | 131 +++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_scoreboard_if.sv
// Decode-stage hazard/forwarding/register-file bus between the decoder and the scoreboard.
interface id_hazard_scoreboard_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NREAD = 2,
    parameter int unsigned DEPTH = 3
);
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                  issue_valid;
    logic                  issue_ready;
    logic [NREAD*AW-1:0]   rs_addr;
    logic [NREAD-1:0]      rs_used;
    logic [AW-1:0]         rd_addr;
    logic                  rd_wen;
    logic                  rd_is_load;
    logic                  flush;
    logic                  wb_valid;
    logic [AW-1:0]         wb_addr;
    logic [XLEN-1:0]       wb_data;
    logic [NREAD*XLEN-1:0] rs_data;
    logic [NREAD*FW-1:0]   fwd_sel;
    logic [31:0]           stall_count;

    // Decoder side: drives the ID instruction and the WB write.
    modport master (
        output issue_valid, rs_addr, rs_used, rd_addr, rd_wen, rd_is_load,
               flush, wb_valid, wb_addr, wb_data,
        input  issue_ready, rs_data, fwd_sel, stall_count
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, rs_addr, rs_used, rd_addr, rd_wen, rd_is_load,
               flush, wb_valid, wb_addr, wb_data,
        output issue_ready, rs_data, fwd_sel, stall_count
    );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage register file with write-through bypass, plus a shift-register
// scoreboard of in-flight destinations that yields forwarding selects and load-use stalls.
module id_hazard_scoreboard #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NREGS        = 32,
    parameter int unsigned NREAD        = 2,
    parameter int unsigned DEPTH        = 3,
    parameter int unsigned LOAD_FWD     = 2,
    parameter int unsigned FLUSH_STAGES = 1
) (
    input logic                   clk,
    input logic                   reset,
    id_hazard_scoreboard_if.slave bus
);
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          load;
    } sb_entry_t;

    sb_entry_t             sb      [1:DEPTH];
    sb_entry_t             sb_next [1:DEPTH];
    logic [XLEN-1:0]       rf      [NREGS];
    logic [NREAD-1:0]      hazard_c;
    logic [NREAD*FW-1:0]   fwd_sel_c;
    logic [NREAD*XLEN-1:0] rs_data_c;
    logic                  issue_ready_c;
    logic                  enter_c;
    logic [31:0]           stall_count;

    // Per-port youngest-match search: scan oldest to youngest so the youngest hit overwrites.
    always_comb begin
        int        hit_s;
        logic      hit_load;
        logic [AW-1:0] src;
        hazard_c  = '0;
        fwd_sel_c = '0;
        hit_s     = 0;
        hit_load  = 1'b0;
        src       = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            hit_s    = 0;
            hit_load = 1'b0;
            src      = bus.rs_addr[i*AW +: AW];
            for (int s = int'(DEPTH); s >= 1; s--) begin
                if (bus.rs_used[i] && src != '0 && sb[s].valid && sb[s].rd == src) begin
                    hit_s    = s;
                    hit_load = sb[s].load;
                end
            end
            // A hit in the last stage is already in the register file (or being bypassed).
            if (hit_s != 0 && hit_s < int'(DEPTH)) begin
                if (hit_load && hit_s < int'(LOAD_FWD)) begin
                    hazard_c[i] = 1'b1;
                end else begin
                    fwd_sel_c[i*FW +: FW] = FW'(hit_s);
                end
            end
        end
    end

    assign issue_ready_c = ~|hazard_c;
    assign enter_c       = bus.issue_valid & issue_ready_c & bus.rd_wen
                         & (bus.rd_addr != '0) & ~bus.flush;

    // Register-file read with same-cycle WB bypass; x0 always reads zero.
    always_comb begin
        logic [AW-1:0] rd_src;
        rs_data_c = '0;
        rd_src    = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            rd_src = bus.rs_addr[i*AW +: AW];
            if (rd_src != '0) begin
                if (bus.wb_valid && bus.wb_addr == rd_src) begin
                    rs_data_c[i*XLEN +: XLEN] = bus.wb_data;
                end else begin
                    rs_data_c[i*XLEN +: XLEN] = rf[rd_src];
                end
            end
        end
    end

    // Next scoreboard: new entry (or bubble) at stage 1, everything else shifts; flush kills early stages.
    always_comb begin
        sb_next[1]       = '0;
        sb_next[1].valid = enter_c;
        sb_next[1].rd    = bus.rd_addr;
        sb_next[1].load  = bus.rd_is_load;
        for (int s = 2; s <= int'(DEPTH); s++) begin
            sb_next[s] = sb[s-1];
            if (bus.flush && (s - 1) <= int'(FLUSH_STAGES)) begin
                sb_next[s].valid = 1'b0;
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 1; s <= int'(DEPTH); s++) sb[s] <= '0;
        end else begin
            for (int s = 1; s <= int'(DEPTH); s++) sb[s] <= sb_next[s];
        end
    end

    // Architectural register file; writes to x0 are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < int'(NREGS); r++) rf[r] <= '0;
        end else if (bus.wb_valid && bus.wb_addr != '0) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Saturating stall counter; a flushed ID instruction is not a stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (bus.issue_valid && !issue_ready_c && !bus.flush && stall_count != '1) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    assign bus.issue_ready = issue_ready_c;
    assign bus.fwd_sel     = fwd_sel_c;
    assign bus.rs_data     = rs_data_c;
    assign bus.stall_count = stall_count;
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed plus random bench for id_hazard_scoreboard against an issue-history reference model.
module tb_id_hazard_scoreboard;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned NREGS        = 32;
    localparam int unsigned NREAD        = 2;
    localparam int unsigned DEPTH        = 3;
    localparam int unsigned LOAD_FWD     = 2;
    localparam int unsigned FLUSH_STAGES = 1;
    localparam int unsigned AW           = 5;
    localparam int unsigned FW           = 2;
    localparam int unsigned HMAX         = 2048;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   now;

    // Reference model: what entered the pipe in each cycle, plus register contents.
    logic            h_valid [HMAX];
    logic [AW-1:0]   h_rd    [HMAX];
    logic            h_load  [HMAX];
    logic [XLEN-1:0] m_rf    [NREGS];
    logic [31:0]     m_stall;

    id_hazard_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .DEPTH(DEPTH)) bus ();

    id_hazard_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .DEPTH(DEPTH),
        .LOAD_FWD(LOAD_FWD), .FLUSH_STAGES(FLUSH_STAGES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < int'(HMAX); t++) h_valid[t] = 1'b0;
        for (int r = 0; r < int'(NREGS); r++) m_rf[r] = '0;
        m_stall = '0;
    endtask

    // Instruction issued s cycles ago sits at stage s; the first live one found is the youngest.
    function automatic void ref_port(input int i, output int sel, output bit haz);
        logic [AW-1:0] a;
        int t;
        a   = bus.rs_addr[i*AW +: AW];
        sel = 0;
        haz = 1'b0;
        if (!bus.rs_used[i] || a == '0) return;
        for (int s = 1; s <= int'(DEPTH); s++) begin
            t = now - s;
            if (t >= 0 && h_valid[t] && h_rd[t] == a) begin
                if (s < int'(DEPTH)) begin
                    if (h_load[t] && s < int'(LOAD_FWD)) haz = 1'b1;
                    else sel = s;
                end
                return;
            end
        end
    endfunction

    function automatic logic [XLEN-1:0] ref_data(input int i);
        logic [AW-1:0] a;
        a = bus.rs_addr[i*AW +: AW];
        if (a == '0) return '0;
        if (bus.wb_valid && bus.wb_addr == a) return bus.wb_data;
        return m_rf[a];
    endfunction

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.rs_addr     = '0;
        bus.rs_used     = '0;
        bus.rd_addr     = '0;
        bus.rd_wen      = 1'b0;
        bus.rd_is_load  = 1'b0;
        bus.flush       = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
    endtask

    task automatic set_src(input int p, input int a, input bit used);
        bus.rs_addr[p*AW +: AW] = AW'(a);
        bus.rs_used[p]          = used;
    endtask

    task automatic issue_dst(input int rd, input bit load);
        bus.issue_valid = 1'b1;
        bus.rd_wen      = 1'b1;
        bus.rd_addr     = AW'(rd);
        bus.rd_is_load  = load;
    endtask

    // Compare all outputs with the model, advance the model, then cross one clock edge.
    task automatic tick();
        int sel;
        bit haz;
        bit rdy;
        #1;
        rdy = 1'b1;
        for (int i = 0; i < int'(NREAD); i++) begin
            ref_port(i, sel, haz);
            if (haz) rdy = 1'b0;
            chk($sformatf("fwd_sel%0d@%0d", i, now), 64'(bus.fwd_sel[i*FW +: FW]), 64'(sel));
            chk($sformatf("rs_data%0d@%0d", i, now), 64'(bus.rs_data[i*XLEN +: XLEN]), 64'(ref_data(i)));
        end
        chk($sformatf("issue_ready@%0d", now), 64'(bus.issue_ready), 64'(rdy));
        chk($sformatf("stall_count@%0d", now), 64'(bus.stall_count), 64'(m_stall));
        if (bus.issue_valid && !rdy && !bus.flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (bus.flush) begin
            for (int s = 1; s <= int'(FLUSH_STAGES); s++) if (now - s >= 0) h_valid[now - s] = 1'b0;
        end
        h_valid[now] = bus.issue_valid && rdy && bus.rd_wen && bus.rd_addr != '0 && !bus.flush;
        h_rd[now]    = bus.rd_addr;
        h_load[now]  = bus.rd_is_load;
        if (bus.wb_valid && bus.wb_addr != '0) m_rf[bus.wb_addr] = bus.wb_data;
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic random_cycle();
        idle();
        bus.issue_valid = ($urandom_range(0, 3) != 0);
        bus.rd_addr     = AW'($urandom_range(0, 7));
        bus.rd_wen      = ($urandom_range(0, 3) != 0);
        bus.rd_is_load  = ($urandom_range(0, 2) == 0);
        bus.flush       = ($urandom_range(0, 9) == 0);
        for (int p = 0; p < int'(NREAD); p++) begin
            set_src(p, int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
        end
        bus.wb_valid = ($urandom_range(0, 1) == 1);
        bus.wb_addr  = AW'($urandom_range(0, 7));
        bus.wb_data  = XLEN'($urandom);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        now    = 0;
        model_reset();
        idle();
        reset = 1'b0;

        // Reset state, with a live read in ID.
        #12;
        set_src(0, 5, 1'b1);
        #1;
        chk("rst_ready", 64'(bus.issue_ready), 64'd1);
        chk("rst_fwd", 64'(bus.fwd_sel), 64'd0);
        chk("rst_data", 64'(bus.rs_data[XLEN-1:0]), 64'd0);
        chk("rst_stall", 64'(bus.stall_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ALU RAW: forward from stage 1, then 2, then from the register file.
        idle(); issue_dst(5, 1'b0); tick();
        idle(); bus.issue_valid = 1'b1; set_src(0, 5, 1'b1);
        #1; chk("raw_sel1", 64'(bus.fwd_sel[FW-1:0]), 64'd1); chk("raw_rdy", 64'(bus.issue_ready), 64'd1);
        tick();
        idle(); bus.issue_valid = 1'b1; set_src(0, 5, 1'b1);
        #1; chk("raw_sel2", 64'(bus.fwd_sel[FW-1:0]), 64'd2);
        tick();
        idle(); bus.issue_valid = 1'b1; set_src(0, 5, 1'b1);
        #1; chk("raw_sel0", 64'(bus.fwd_sel[FW-1:0]), 64'd0);
        tick();

        // Load-use: one stall cycle, then forward from stage 2.
        idle(); issue_dst(7, 1'b1); tick();
        idle(); bus.issue_valid = 1'b1; set_src(0, 7, 1'b1);
        #1; chk("lu_stall_rdy", 64'(bus.issue_ready), 64'd0);
        tick();
        idle(); bus.issue_valid = 1'b1; set_src(0, 7, 1'b1);
        #1; chk("lu_rdy", 64'(bus.issue_ready), 64'd1); chk("lu_sel2", 64'(bus.fwd_sel[FW-1:0]), 64'd2);
        chk("lu_count", 64'(bus.stall_count), 64'd1);
        tick();

        // Priority: youngest writer wins; x0 and unused ports never forward.
        idle(); issue_dst(3, 1'b0); tick();
        idle(); issue_dst(3, 1'b0); tick();
        idle(); bus.issue_valid = 1'b1; set_src(0, 3, 1'b1); set_src(1, 3, 1'b0);
        #1; chk("prio_young", 64'(bus.fwd_sel[FW-1:0]), 64'd1);
        chk("prio_unused", 64'(bus.fwd_sel[2*FW-1:FW]), 64'd0);
        tick();
        idle(); bus.issue_valid = 1'b1; set_src(0, 0, 1'b1);
        #1; chk("prio_x0", 64'(bus.fwd_sel[FW-1:0]), 64'd0); chk("prio_x0_rdy", 64'(bus.issue_ready), 64'd1);
        tick();

        // Flush beats a load-use hazard and kills the load in stage 1.
        idle(); issue_dst(9, 1'b1); tick();
        idle(); bus.issue_valid = 1'b1; set_src(0, 9, 1'b1); bus.flush = 1'b1; tick();
        idle(); bus.issue_valid = 1'b1; set_src(0, 9, 1'b1);
        #1; chk("flush_sel", 64'(bus.fwd_sel[FW-1:0]), 64'd0); chk("flush_rdy", 64'(bus.issue_ready), 64'd1);
        chk("flush_count", 64'(bus.stall_count), 64'd1);
        tick();

        // Write-through bypass and x0 writes.
        idle(); set_src(1, 4, 1'b1); bus.wb_valid = 1'b1; bus.wb_addr = AW'(4); bus.wb_data = 32'hDEAD_BEEF;
        #1; chk("wt_bypass", 64'(bus.rs_data[2*XLEN-1:XLEN]), 64'hDEAD_BEEF);
        tick();
        idle(); set_src(0, 0, 1'b1); bus.wb_valid = 1'b1; bus.wb_addr = '0; bus.wb_data = 32'h1234_5678;
        #1; chk("wt_x0_same", 64'(bus.rs_data[XLEN-1:0]), 64'd0);
        tick();
        idle(); set_src(0, 0, 1'b1); set_src(1, 4, 1'b1);
        #1; chk("wt_x0_after", 64'(bus.rs_data[XLEN-1:0]), 64'd0);
        chk("wt_x4_rf", 64'(bus.rs_data[2*XLEN-1:XLEN]), 64'hDEAD_BEEF);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) random_cycle();

        // Reset mid-stream with a load pending in stage 1.
        idle(); issue_dst(7, 1'b1); tick();
        idle(); bus.issue_valid = 1'b1; set_src(0, 7, 1'b1); set_src(1, 5, 1'b1);
        #1; chk("mr_pre_rdy", 64'(bus.issue_ready), 64'd0);
        reset = 1'b0;
        #1;
        model_reset();
        chk("mr_rdy", 64'(bus.issue_ready), 64'd1);
        chk("mr_count", 64'(bus.stall_count), 64'd0);
        chk("mr_fwd", 64'(bus.fwd_sel), 64'd0);
        chk("mr_data", 64'(bus.rs_data), 64'd0);
        reset = 1'b1;
        tick();
        for (int n = 0; n < 40; n++) random_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
